// File: rtl/cajero_multi.sv
// cajero_multi: ATM transaction controller.
// Takes a card, collects a PIN digit by digit and checks it. Repeated wrong
// PINs lead to a permanent lockout. A correct PIN allows one deposit or one
// withdrawal against the balance latched when the card was accepted.
//
// state           | meaning
// ----------------+----------------------------------------------------------
// IDLE            | waiting for a card; pin/balance are latched on acceptance
// RECIBIENDO_PIN  | shifting BCD digits into the entry register
// COMPARAR_PIN    | one cycle: compare entry with card PIN, update attempts
// ESPERANDO_MONTO | waiting for the amount strobe
// TRANSACCION     | one cycle: apply deposit/withdrawal, publish the balance
// BLOQUEO         | locked; only reset leaves this state
module cajero_multi #(
    parameter int PIN_DIGITS   = 4,
    parameter int MAX_INTENTOS = 3,
    parameter int BALANCE_W    = 32,
    parameter int MONTO_W      = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tarjeta_recibida,
    input  logic                    tipo_trans,
    input  logic                    digito_stb,
    input  logic [3:0]              digito,
    input  logic [4*PIN_DIGITS-1:0] pin,
    input  logic [BALANCE_W-1:0]    balance_inicial,
    input  logic                    monto_stb,
    input  logic [MONTO_W-1:0]      monto,
    output logic [BALANCE_W-1:0]    balance_actualizado,
    output logic                    balance_stb,
    output logic                    entregar_dinero,
    output logic                    pin_incorrecto,
    output logic                    advertencia,
    output logic                    bloqueo,
    output logic                    fondos_insuficientes
);

    localparam int PW  = 4 * PIN_DIGITS;
    localparam int DCW = $clog2(PIN_DIGITS + 1);
    localparam int ICW = $clog2(MAX_INTENTOS + 1);
    localparam logic [DCW-1:0] ULTIMO = DCW'(PIN_DIGITS - 1);
    localparam logic [ICW-1:0] AVISO  = ICW'(MAX_INTENTOS - 1);
    localparam logic [ICW-1:0] LIMITE = ICW'(MAX_INTENTOS);

    typedef enum logic [2:0] {
        IDLE, RECIBIENDO_PIN, COMPARAR_PIN, ESPERANDO_MONTO, TRANSACCION, BLOQUEO
    } state_t;

    state_t state, state_n;

    logic [PW-1:0]        pin_q, pin_d, entrada_q, entrada_d;
    logic [BALANCE_W-1:0] saldo_q, saldo_d, bal_d;
    logic [DCW-1:0]       dcnt_q, dcnt_d;
    logic [ICW-1:0]       intentos_q, intentos_d, intentos_inc;
    logic [MONTO_W-1:0]   monto_q, monto_d;
    logic                 tipo_q, tipo_d;
    logic                 bstb_d, entr_d, pinc_d, adv_d, bloq_d, fondos_d;
    logic                 digito_ok, pin_ok;
    logic [BALANCE_W:0]   saldo_ext, monto_ext, suma;
    logic [BALANCE_W-1:0] resta;

    assign digito_ok    = digito_stb && (digito <= 4'd9);
    assign pin_ok       = (entrada_q == pin_q);
    assign intentos_inc = intentos_q + ICW'(1);
    assign saldo_ext    = {1'b0, saldo_q};
    assign monto_ext    = {{(BALANCE_W + 1 - MONTO_W){1'b0}}, monto_q};
    assign suma         = saldo_ext + monto_ext;
    // only used when no borrow is possible, so the low bits are exact
    assign resta        = saldo_q - monto_ext[BALANCE_W-1:0];

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next-state decode; card removal outranks any same-cycle strobe
    always_comb begin
        state_n = state;
        case (state)
            IDLE:            if (tarjeta_recibida) state_n = RECIBIENDO_PIN;
            RECIBIENDO_PIN: begin
                if (!tarjeta_recibida)                  state_n = IDLE;
                else if (digito_ok && dcnt_q == ULTIMO) state_n = COMPARAR_PIN;
            end
            COMPARAR_PIN: begin
                if (pin_ok)                       state_n = ESPERANDO_MONTO;
                else if (intentos_inc == LIMITE)  state_n = BLOQUEO;
                else                              state_n = RECIBIENDO_PIN;
            end
            ESPERANDO_MONTO: begin
                if (!tarjeta_recibida) state_n = IDLE;
                else if (monto_stb)    state_n = TRANSACCION;
            end
            TRANSACCION:     state_n = IDLE;
            BLOQUEO:         state_n = BLOQUEO;
            default:         state_n = IDLE;
        endcase
    end

    // datapath and output next values; pulses default low every cycle
    always_comb begin
        pin_d      = pin_q;
        saldo_d    = saldo_q;
        entrada_d  = entrada_q;
        dcnt_d     = dcnt_q;
        intentos_d = intentos_q;
        monto_d    = monto_q;
        tipo_d     = tipo_q;
        bal_d      = balance_actualizado;
        adv_d      = advertencia;
        bloq_d     = bloqueo;
        bstb_d     = 1'b0;
        entr_d     = 1'b0;
        pinc_d     = 1'b0;
        fondos_d   = 1'b0;
        case (state)
            IDLE: begin
                if (tarjeta_recibida) begin
                    pin_d     = pin;
                    saldo_d   = balance_inicial;
                    dcnt_d    = '0;
                    entrada_d = '0;
                end
            end
            RECIBIENDO_PIN: begin
                if (tarjeta_recibida && digito_ok) begin
                    entrada_d = (entrada_q << 4) | PW'(digito);
                    dcnt_d    = dcnt_q + DCW'(1);
                end
            end
            COMPARAR_PIN: begin
                if (pin_ok) begin
                    intentos_d = '0;
                    adv_d      = 1'b0;
                end else begin
                    intentos_d = intentos_inc;
                    pinc_d     = 1'b1;
                    dcnt_d     = '0;
                    entrada_d  = '0;
                    if (intentos_inc == AVISO)  adv_d  = 1'b1;
                    if (intentos_inc == LIMITE) bloq_d = 1'b1;
                end
            end
            ESPERANDO_MONTO: begin
                if (tarjeta_recibida && monto_stb) begin
                    monto_d = monto;
                    tipo_d  = tipo_trans;
                end
            end
            TRANSACCION: begin
                bstb_d = 1'b1;
                if (!tipo_q) begin
                    bal_d = suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
                end else if (monto_ext <= saldo_ext) begin
                    bal_d  = resta;
                    entr_d = 1'b1;
                end else begin
                    bal_d    = saldo_q;
                    fondos_d = 1'b1;
                end
            end
            BLOQUEO:  bloq_d = 1'b1;
            default:  ;
        endcase
    end

    // registered datapath and outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pin_q                <= '0;
            saldo_q              <= '0;
            entrada_q            <= '0;
            dcnt_q               <= '0;
            intentos_q           <= '0;
            monto_q              <= '0;
            tipo_q               <= 1'b0;
            balance_actualizado  <= '0;
            balance_stb          <= 1'b0;
            entregar_dinero      <= 1'b0;
            pin_incorrecto       <= 1'b0;
            advertencia          <= 1'b0;
            bloqueo              <= 1'b0;
            fondos_insuficientes <= 1'b0;
        end else begin
            pin_q                <= pin_d;
            saldo_q              <= saldo_d;
            entrada_q            <= entrada_d;
            dcnt_q               <= dcnt_d;
            intentos_q           <= intentos_d;
            monto_q              <= monto_d;
            tipo_q               <= tipo_d;
            balance_actualizado  <= bal_d;
            balance_stb          <= bstb_d;
            entregar_dinero      <= entr_d;
            pin_incorrecto       <= pinc_d;
            advertencia          <= adv_d;
            bloqueo              <= bloq_d;
            fondos_insuficientes <= fondos_d;
        end
    end

endmodule
